row_buffer_writer: RTL

//  Write side of the 4-row ifmap ring buffer. Packs the incoming pixel stream into rows and

---
 rtl/row_buffer_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/row_buffer_writer.sv
// -----------------------------------------------------------------------------
// row_buffer_writer
//   Write side of a 4-row ifmap ring buffer. Incoming pixels are packed into
//   rows (pixel 0 in the LSBs) and the four row registers are filled
//   round-robin. A 3-row window is flagged valid once three complete rows are
//   held. The oldest row is retired when the PE array reports the window done.
//   After the last window of a frame a one-cycle frameDone pulse is raised and
//   the block returns to IDLE.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               1-cycle pulse, begins a frame (only honoured in IDLE)
//   inValid, inData     pixel stream input
//   inReady             a pixel is accepted this cycle when inValid & inReady
//   winDone             1-cycle pulse, current window consumed
//   winValid            the 3 rows starting at select are complete
//   select              index of the oldest valid row (0=row1 .. 3=row4)
//   row1Out..row4Out    row registers
//   frameDone           1-cycle pulse after the last window is retired
// -----------------------------------------------------------------------------
module row_buffer_writer #(
    parameter int DATA_W   = 8,
    parameter int ROW_PIX  = 8,
    parameter int IMG_ROWS = 8,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      inValid,
    input  logic [DATA_W-1:0]         inData,
    output logic                      inReady,
    input  logic                      winDone,
    output logic                      winValid,
    output logic [1:0]                select,
    output logic [DATA_W*ROW_PIX-1:0] row1Out,
    output logic [DATA_W*ROW_PIX-1:0] row2Out,
    output logic [DATA_W*ROW_PIX-1:0] row3Out,
    output logic [DATA_W*ROW_PIX-1:0] row4Out,
    output logic                      frameDone
);

    localparam int ROW_W = DATA_W * ROW_PIX;
    localparam int PIX_W = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(ROW_PIX - 1);
    localparam logic [CNT_W-1:0] ROWS_MAX = CNT_W'(IMG_ROWS);
    localparam logic [CNT_W-1:0] LAST_WIN = CNT_W'(IMG_ROWS - 3);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q [4];
    logic [ROW_W-1:0]   row_d [4];
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [2:0]         rows_valid_q, rows_valid_d;
    logic [CNT_W-1:0]   rows_written_q, rows_written_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic               frame_done_q, frame_done_d;

    logic in_ready;
    logic win_valid;
    logic accept;
    logic row_done;
    logic win_take;
    logic last_win;

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            for (int i = 0; i < 4; i++) row_q[i] <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pix_cnt_q      <= '0;
            rows_valid_q   <= '0;
            rows_written_q <= '0;
            win_cnt_q      <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            for (int i = 0; i < 4; i++) row_q[i] <= row_d[i];
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pix_cnt_q      <= pix_cnt_d;
            rows_valid_q   <= rows_valid_d;
            rows_written_q <= rows_written_d;
            win_cnt_q      <= win_cnt_d;
            frame_done_q   <= frame_done_d;
        end
    end

    // Handshake outputs, purely from registered state
    always_comb begin
        in_ready  = (state_q == RUN) && (rows_valid_q < 3'd4) && (rows_written_q < ROWS_MAX);
        win_valid = (state_q == RUN) && (rows_valid_q >= 3'd3);
    end

    assign accept   = inValid & in_ready;
    assign row_done = accept && (pix_cnt_q == LAST_PIX);
    // winDone without a valid window is dropped entirely
    assign win_take = winDone & win_valid;
    assign last_win = win_take && (win_cnt_q == LAST_WIN);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)    state_d = RUN;
            RUN:  if (last_win) state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        for (int i = 0; i < 4; i++) row_d[i] = row_q[i];
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        pix_cnt_d      = pix_cnt_q;
        rows_valid_d   = rows_valid_q;
        rows_written_d = rows_written_q;
        win_cnt_d      = win_cnt_q;
        frame_done_d   = 1'b0;

        if (accept) begin
            row_d[wr_ptr_q][DATA_W*int'(pix_cnt_q) +: DATA_W] = inData;
            if (row_done) begin
                pix_cnt_d      = '0;
                wr_ptr_d       = wr_ptr_q + 2'd1;
                rows_written_d = rows_written_q + 1'b1;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end

        if (win_take) begin
            rd_ptr_d  = rd_ptr_q + 2'd1;
            win_cnt_d = win_cnt_q + 1'b1;
        end

        // A row completing alongside a retired window leaves the count as is
        case ({row_done, win_take})
            2'b10:   rows_valid_d = rows_valid_q + 3'd1;
            2'b01:   rows_valid_d = rows_valid_q - 3'd1;
            default: rows_valid_d = rows_valid_q;
        endcase

        // End of frame: pointers and counters restart, row contents are kept
        if (last_win) begin
            frame_done_d   = 1'b1;
            rows_valid_d   = '0;
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
            pix_cnt_d      = '0;
            rows_written_d = '0;
            win_cnt_d      = '0;
        end
    end

    // Output assignments
    always_comb begin
        inReady   = in_ready;
        winValid  = win_valid;
        select    = rd_ptr_q;
        frameDone = frame_done_q;
        row1Out   = row_q[0];
        row2Out   = row_q[1];
        row3Out   = row_q[2];
        row4Out   = row_q[3];
    end

endmodule
